ahb_apb_bridge_gen2: RTL and testbench

Parametrised AHB-Lite to APB bridge; next generation of the team's fixed 3-slave bridge. Generalised data/address width and slave count; adds base-address decode, PREADY wait states, PSLVERR and decode-miss mapped to a two-cycle AHB ERROR response, and a programmable wait-state timeout. Sits between the AHB fabric and the APB peripheral cluster.

---
 rtl/ahb_apb_bridge_gen2_if.sv | 37 +++
 rtl/ahb_apb_bridge_gen2.sv | 150 +++++++++++++++
 tb/tb_ahb_apb_bridge_gen2.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_bridge_gen2_if.sv
// rtl/ahb_apb_bridge_gen2_if.sv - AHB-Lite / APB signal bundle for the bridge
interface ahb_apb_bridge_gen2_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  // AHB-Lite side
  logic              hwrite;
  logic              hreadyin;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hr_readyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;
  // APB side
  logic [DATA_W-1:0]  prdata;
  logic               pready;
  logic               pslverr;
  logic               penable;
  logic               pwrite;
  logic [NUM_SLV-1:0] psel;
  logic [ADDR_W-1:0]  paddr;
  logic [DATA_W-1:0]  pwdata;

  // Environment view: AHB master plus APB peripheral responses
  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata, prdata, pready, pslverr,
    input  penable, pwrite, hr_readyout, psel, hresp, paddr, pwdata, hrdata
  );

  // Bridge view
  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata, prdata, pready, pslverr,
    output penable, pwrite, hr_readyout, psel, hresp, paddr, pwdata, hrdata
  );
endinterface

// File: rtl/ahb_apb_bridge_gen2.sv
// rtl/ahb_apb_bridge_gen2.sv - parametrised AHB-Lite to APB bridge with decode, waits, errors and timeout
module ahb_apb_bridge_gen2 #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_BITS = 12,
  parameter int                TIMEOUT     = 16
) (
  input  logic                  hclk_i,
  input  logic                  hresetn_i,
  ahb_apb_bridge_gen2_if.slave  bus
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t             state_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;
  logic               pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [DATA_W-1:0]  hrdata_q;
  logic               hr_readyout_q;
  logic [1:0]         hresp_q;
  logic [31:0]        cnt_q;

  logic [ADDR_W-1:0]  off_d;
  logic [ADDR_W-1:0]  idx_d;
  logic               hit_d;
  logic               valid_d;
  logic               timeout_d;
  logic [NUM_SLV-1:0] psel_d;

  // Address decode of the transfer currently on the AHB address phase
  always_comb begin
    off_d   = bus.haddr - BASE_ADDR;
    idx_d   = off_d >> REGION_BITS;
    hit_d   = (bus.haddr >= BASE_ADDR) && (idx_d < ADDR_W'(NUM_SLV));
    valid_d = bus.hreadyin && bus.htrans[1];
    psel_d  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      psel_d[i] = (idx_d == ADDR_W'(i));
    end
    // The counter equals the number of low-pready ACCESS cycles already seen
    timeout_d = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
  end

  // Bridge FSM; every bus output is a register updated alongside the state
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q       <= S_IDLE;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      hrdata_q      <= '0;
      hr_readyout_q <= 1'b1;
      hresp_q       <= RESP_OKAY;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (valid_d && hit_d) begin
            // Write data is captured together with the address so that it is
            // already stable while psel is asserted in SETUP.
            state_q       <= S_SETUP;
            psel_q        <= psel_d;
            paddr_q       <= bus.haddr;
            pwrite_q      <= bus.hwrite;
            if (bus.hwrite) pwdata_q <= bus.hwdata;
            hr_readyout_q <= 1'b0;
            hresp_q       <= RESP_OKAY;
          end else if (valid_d) begin
            state_q       <= S_ERR1;
            hr_readyout_q <= 1'b0;
            hresp_q       <= RESP_ERROR;
          end else begin
            state_q       <= S_IDLE;
            hr_readyout_q <= 1'b1;
            hresp_q       <= RESP_OKAY;
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          if (bus.pready || timeout_d) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            if (bus.pready && !bus.pslverr) begin
              state_q       <= S_DONE;
              hr_readyout_q <= 1'b1;
              hresp_q       <= RESP_OKAY;
              if (!pwrite_q) hrdata_q <= bus.prdata;
            end else begin
              state_q       <= S_ERR1;
              hr_readyout_q <= 1'b0;
              hresp_q       <= RESP_ERROR;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_ERR1: begin
          state_q       <= S_ERR2;
          hr_readyout_q <= 1'b1;
          hresp_q       <= RESP_ERROR;
        end
        S_ERR2: begin
          // The master cancels whatever it presents here, so nothing is sampled
          state_q       <= S_IDLE;
          hr_readyout_q <= 1'b1;
          hresp_q       <= RESP_OKAY;
        end
        default: begin
          state_q       <= S_IDLE;
          psel_q        <= '0;
          penable_q     <= 1'b0;
          hr_readyout_q <= 1'b1;
          hresp_q       <= RESP_OKAY;
          cnt_q         <= '0;
        end
      endcase
    end
  end

  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.hrdata      = hrdata_q;
  assign bus.hr_readyout = hr_readyout_q;
  assign bus.hresp       = hresp_q;

endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// tb/tb_ahb_apb_bridge_gen2.sv - directed self-checking bench for ahb_apb_bridge_gen2
module tb_ahb_apb_bridge_gen2;

  logic hclk;
  logic hresetn;
  int   total;
  int   bad;

  ahb_apb_bridge_gen2_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

  ahb_apb_bridge_gen2 dut (
    .hclk_i    (hclk),
    .hresetn_i (hresetn),
    .bus       (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [31:0] d);
    bus.htrans   = tr;
    bus.haddr    = a;
    bus.hwrite   = wr;
    bus.hwdata   = d;
    bus.hreadyin = 1'b1;
  endtask

  // Plays the APB slave from SETUP until psel drops; returns at the negedge of
  // the first cycle without psel (DONE or ERR1).
  task automatic respond(input int waits, input logic err, input logic [31:0] rd,
                         output int nsel, output int nacc);
    int  acc;
    bit  ended;
    acc   = 0;
    nsel  = 0;
    nacc  = 0;
    ended = 0;
    for (int c = 0; c < 40 && !ended; c++) begin
      @(posedge hclk); #1;
      bus.htrans = 2'b00;
      if (bus.penable) begin
        bus.pready  = (acc == waits);
        bus.pslverr = err && (acc == waits);
        bus.prdata  = rd;
        acc++;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end
      @(negedge hclk);
      if (bus.psel != 4'b0) nsel++;
      else ended = 1;
      if (bus.penable) nacc++;
    end
    if (!ended) check("respond_bound", 64'd0, 64'd1);
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
  endtask

  // Called at the ERR1 negedge; optionally presents a transfer during ERR2
  task automatic err_seq(input string tag, input bit poke);
    check({tag, "_e1_rdy"}, bus.hr_readyout, 1'b0);
    check({tag, "_e1_resp"}, bus.hresp, 2'b01);
    check({tag, "_e1_psel"}, bus.psel, 4'b0);
    @(posedge hclk); #1;
    if (poke) drive(2'b10, 32'h8000_0000, 1'b1, 32'h1111_2222);
    @(negedge hclk);
    check({tag, "_e2_rdy"}, bus.hr_readyout, 1'b1);
    check({tag, "_e2_resp"}, bus.hresp, 2'b01);
    @(posedge hclk); #1;
    bus.htrans = 2'b00;
    @(negedge hclk);
    check({tag, "_idle_resp"}, bus.hresp, 2'b00);
    check({tag, "_idle_rdy"}, bus.hr_readyout, 1'b1);
    check({tag, "_idle_psel"}, bus.psel, 4'b0);
  endtask

  int nsel;
  int nacc;

  initial begin
    total   = 0;
    bad     = 0;
    hresetn = 1'b0;
    drive(2'b00, 32'h0, 1'b0, 32'h0);
    bus.prdata  = 32'h0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_psel", bus.psel, 4'b0);
    check("rst_penable", bus.penable, 1'b0);
    check("rst_pwrite", bus.pwrite, 1'b0);
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_hrdata", bus.hrdata, 32'h0);
    check("rst_hresp", bus.hresp, 2'b00);
    check("rst_rdy", bus.hr_readyout, 1'b1);
    hresetn = 1'b1;

    // Zero-wait write to slave 1
    @(posedge hclk); #1;
    drive(2'b10, 32'h8000_1004, 1'b1, 32'hDEAD_BEEF);
    bus.pready = 1'b1;
    @(posedge hclk); #1;
    bus.htrans = 2'b00;
    @(negedge hclk);
    check("wr_t1_psel", bus.psel, 4'b0010);
    check("wr_t1_pen", bus.penable, 1'b0);
    check("wr_t1_paddr", bus.paddr, 32'h8000_1004);
    check("wr_t1_pwdata", bus.pwdata, 32'hDEAD_BEEF);
    check("wr_t1_pwrite", bus.pwrite, 1'b1);
    check("wr_t1_rdy", bus.hr_readyout, 1'b0);
    @(negedge hclk);
    check("wr_t2_pen", bus.penable, 1'b1);
    check("wr_t2_psel", bus.psel, 4'b0010);
    @(negedge hclk);
    check("wr_t3_rdy", bus.hr_readyout, 1'b1);
    check("wr_t3_resp", bus.hresp, 2'b00);
    check("wr_t3_psel", bus.psel, 4'b0);
    check("wr_t3_pen", bus.penable, 1'b0);
    bus.pready = 1'b0;

    // Read from slave 3 with three wait states
    @(posedge hclk); #1;
    drive(2'b10, 32'h8000_3010, 1'b0, 32'h0);
    respond(3, 1'b0, 32'h1234_5678, nsel, nacc);
    check("rd_nsel", nsel, 5);
    check("rd_rdy", bus.hr_readyout, 1'b1);
    check("rd_hrdata", bus.hrdata, 32'h1234_5678);
    check("rd_resp", bus.hresp, 2'b00);
    check("rd_pwdata_hold", bus.pwdata, 32'hDEAD_BEEF);

    // Decode misses: index past NUM_SLV, then below the window
    @(posedge hclk); #1;
    drive(2'b10, 32'h8000_4000, 1'b0, 32'h0);
    respond(3, 1'b0, 32'h0, nsel, nacc);
    check("miss_hi_nsel", nsel, 0);
    err_seq("miss_hi", 1'b1);
    @(posedge hclk); #1;
    drive(2'b11, 32'h7FFF_FFFC, 1'b0, 32'h0);
    respond(3, 1'b0, 32'h0, nsel, nacc);
    check("miss_lo_nsel", nsel, 0);
    err_seq("miss_lo", 1'b0);
    check("miss_paddr_hold", bus.paddr, 32'h8000_3010);

    // Slave error on a write
    @(posedge hclk); #1;
    drive(2'b10, 32'h8000_0000, 1'b1, 32'hA5A5_0001);
    respond(0, 1'b1, 32'h0, nsel, nacc);
    check("slverr_nsel", nsel, 2);
    err_seq("slverr", 1'b0);
    check("slverr_pwdata", bus.pwdata, 32'hA5A5_0001);

    // Wait-state timeout on a read; hrdata must not change
    @(posedge hclk); #1;
    drive(2'b10, 32'h8000_2000, 1'b0, 32'h0);
    respond(1000, 1'b0, 32'hFFFF_FFFF, nsel, nacc);
    check("to_nacc", nacc, 16);
    check("to_nsel", nsel, 17);
    err_seq("to", 1'b0);
    check("to_hrdata", bus.hrdata, 32'h1234_5678);

    // Back-to-back NONSEQ write then SEQ read offered in DONE
    @(posedge hclk); #1;
    drive(2'b10, 32'h8000_1008, 1'b1, 32'h0BAD_F00D);
    respond(0, 1'b0, 32'h0, nsel, nacc);
    check("b2b_done_rdy", bus.hr_readyout, 1'b1);
    drive(2'b11, 32'h8000_0004, 1'b0, 32'h0);
    @(negedge hclk);
    check("b2b_setup_psel", bus.psel, 4'b0001);
    check("b2b_setup_pen", bus.penable, 1'b0);
    check("b2b_setup_paddr", bus.paddr, 32'h8000_0004);
    check("b2b_setup_pwrite", bus.pwrite, 1'b0);
    check("b2b_setup_rdy", bus.hr_readyout, 1'b0);
    @(posedge hclk); #1;
    bus.htrans = 2'b00;
    bus.pready = 1'b1;
    bus.prdata = 32'hCAFE_0001;
    @(negedge hclk);
    check("b2b_acc_pen", bus.penable, 1'b1);
    @(negedge hclk);
    check("b2b_hrdata", bus.hrdata, 32'hCAFE_0001);
    check("b2b_rdy", bus.hr_readyout, 1'b1);
    check("b2b_pwdata", bus.pwdata, 32'h0BAD_F00D);
    bus.pready = 1'b0;

    // Asynchronous reset while in ACCESS
    @(posedge hclk); #1;
    drive(2'b10, 32'h8000_3000, 1'b1, 32'h5555_AAAA);
    @(posedge hclk); #1;
    bus.htrans = 2'b00;
    @(negedge hclk);
    @(negedge hclk);
    check("ar_pen_before", bus.penable, 1'b1);
    #2 hresetn = 1'b0;
    #1;
    check("ar_psel", bus.psel, 4'b0);
    check("ar_pen", bus.penable, 1'b0);
    check("ar_rdy", bus.hr_readyout, 1'b1);
    check("ar_hrdata", bus.hrdata, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    check("ar_idle_psel", bus.psel, 4'b0);
    check("ar_idle_resp", bus.hresp, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
